// File: rtl/alu_muldiv_pkg.sv
// Shared types and op-decoding helpers for the iterative multiply/divide unit.
// Op groups follow the RV M-extension encoding order.
package alu_muldiv_pkg;

    typedef enum logic [2:0] {
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE, CALC, SIGN, DONE
    } md_state_e;

    function automatic logic is_div_op(input md_op_e op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

    function automatic logic is_rem_op(input md_op_e op);
        return op inside {REM, REMU};
    endfunction

    function automatic logic is_mulh_op(input md_op_e op);
        return op inside {MULH, MULHSU, MULHU};
    endfunction

    function automatic logic a_signed(input md_op_e op);
        return op inside {MUL, MULH, MULHSU, DIV, REM};
    endfunction

    function automatic logic b_signed(input md_op_e op);
        return op inside {MUL, MULH, DIV, REM};
    endfunction

endpackage

// File: rtl/alu_muldiv_sign_conv.sv
// Combinational conditional negate: returns -val_i when neg_i is set, else val_i.
// Used both to take operand magnitudes and to re-apply the result sign.
module md_sign_conv #(
    parameter int Width = 32
) (
    input  logic [Width-1:0] val_i,
    input  logic             neg_i,
    output logic [Width-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + 1'b1) : val_i;

endmodule

// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply/divide for the RV M-extension ops.
// One shared accumulator: shift-add for multiply, restoring shift-subtract for divide.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  md_op_e           op_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             kill_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] result_o,
    output logic             busy_o
);

    localparam int CntW = $clog2(Width);
    localparam int AccW = 2 * Width + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);
    localparam logic [Width-1:0] MinNeg = {1'b1, {(Width-1){1'b0}}};

    md_state_e        state_q, state_d;
    md_op_e           op_q, op_d;
    logic [AccW-1:0]  acc_q, acc_d;
    logic [Width-1:0] opnd_q, opnd_d;
    logic [Width-1:0] result_q, result_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             res_neg_q, res_neg_d;

    logic             accept;
    logic             a_neg, b_neg;
    logic [Width-1:0] a_mag, b_mag;
    logic             div_by_zero, div_ovf;
    logic [Width-1:0] special_res;
    logic [Width:0]   mul_partial;
    logic [AccW-1:0]  mul_next;
    logic [AccW-1:0]  div_shift;
    logic [Width:0]   div_trial;
    logic [AccW-1:0]  div_next;
    logic [Width-1:0] acc_hi, acc_lo;
    logic [Width-1:0] post_in, post_out, post_res;

    assign accept = in_valid_i && (state_q == IDLE) && !kill_i;

    // Operand magnitudes, taken straight off the inputs at accept time.
    assign a_neg = a_signed(op_i) && a_i[Width-1];
    assign b_neg = b_signed(op_i) && b_i[Width-1];

    md_sign_conv #(.Width(Width)) u_conv_a (.val_i(a_i), .neg_i(a_neg), .res_o(a_mag));
    md_sign_conv #(.Width(Width)) u_conv_b (.val_i(b_i), .neg_i(b_neg), .res_o(b_mag));

    assign div_by_zero = is_div_op(op_i) && (b_i == '0);
    assign div_ovf     = (op_i inside {DIV, REM}) && (a_i == MinNeg) && (b_i == '1);

    always_comb begin
        special_res = '0;
        if (div_by_zero) special_res = is_rem_op(op_i) ? a_i : '1;
        else if (div_ovf) special_res = is_rem_op(op_i) ? '0 : a_i;
    end

    // Multiply step: conditionally add multiplicand into the high half, then shift right.
    assign mul_partial = acc_q[0] ? (acc_q[AccW-1:Width] + {1'b0, opnd_q}) : acc_q[AccW-1:Width];
    assign mul_next    = {1'b0, mul_partial, acc_q[Width-1:1]};

    // Divide step: shift left, trial subtract, keep it and set quotient bit if non-negative.
    assign div_shift = {acc_q[AccW-2:0], 1'b0};
    assign div_trial = div_shift[AccW-1:Width] - {1'b0, opnd_q};
    assign div_next  = div_trial[Width] ? div_shift : {div_trial, div_shift[Width-1:1], 1'b1};

    assign acc_hi  = acc_q[2*Width-1:Width];
    assign acc_lo  = acc_q[Width-1:0];
    assign post_in = (is_mulh_op(op_q) || is_rem_op(op_q)) ? acc_hi : acc_lo;

    md_sign_conv #(.Width(Width)) u_conv_res (.val_i(post_in), .neg_i(res_neg_q), .res_o(post_out));

    // High half of a negated 2W-bit product only takes the +1 carry when the low half is zero.
    assign post_res = (is_mulh_op(op_q) && res_neg_q && (acc_lo != '0)) ? ~acc_hi : post_out;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        res_neg_d = res_neg_q;
        result_d  = result_q;
        if (kill_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_d      = op_i;
                        cnt_d     = '0;
                        res_neg_d = is_rem_op(op_i) ? a_neg : (a_neg ^ b_neg);
                        if (div_by_zero || div_ovf) begin
                            result_d = special_res;
                            state_d  = DONE;
                        end else if (is_div_op(op_i)) begin
                            acc_d   = {{(Width+1){1'b0}}, a_mag};
                            opnd_d  = b_mag;
                            state_d = CALC;
                        end else begin
                            acc_d   = {{(Width+1){1'b0}}, b_mag};
                            opnd_d  = a_mag;
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    acc_d = is_div_op(op_q) ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntLast) state_d = SIGN;
                end
                SIGN: begin
                    result_d = post_res;
                    state_d  = DONE;
                end
                DONE: begin
                    if (out_ready_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            op_q      <= MUL;
            acc_q     <= '0;
            opnd_q    <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            res_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            res_neg_q <= res_neg_d;
        end
    end

    // Handshake: a request is taken on a rising edge with in_valid_i && in_ready_o && !kill_i;
    // a result is taken on a rising edge with out_valid_o && out_ready_i && !kill_i.
    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign result_o    = result_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: directed corner ops, backpressure, flush and reset,
// then randomized ops checked against an arithmetic reference model.
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    md_op_e       op = MUL;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_valid = 1'b0;
    logic         kill = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready, out_valid, busy;
    logic [W-1:0] result;

    int n_checks = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];

    alu_muldiv #(.Width(W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .op_i(op), .a_i(a), .b_i(b),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .kill_i(kill),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .result_o(result), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic with the architectural special cases.
    function automatic logic [W-1:0] ref_md(input md_op_e o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, p;
        longint unsigned ux, uy, up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            MUL:    begin p = sx * sy; return p[31:0]; end
            MULH:   begin p = sx * sy; return p[63:32]; end
            MULHSU: begin p = sx * longint'(uy); return p[63:32]; end
            MULHU:  begin up = ux * uy; return up[63:32]; end
            DIV: begin
                if (y == 0) return '1;
                if (x == 32'h8000_0000 && y == '1) return x;
                p = sx / sy; return p[31:0];
            end
            DIVU: begin
                if (y == 0) return '1;
                up = ux / uy; return up[31:0];
            end
            REM: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == '1) return '0;
                p = sx % sy; return p[31:0];
            end
            default: begin
                if (y == 0) return x;
                up = ux % uy; return up[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input md_op_e o, input logic [W-1:0] x, input logic [W-1:0] y);
        if (o inside {DIV, DIVU, REM, REMU} && y == 0) return 1;
        if (o inside {DIV, REM} && x == 32'h8000_0000 && y == '1) return 1;
        return W + 2;
    endfunction

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'd1;
            4: return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    // Drives one op; kill_at>0 flushes in that cycle after accept, kill_done flushes in DONE.
    task automatic run_op(input md_op_e o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int hold, input int kill_at, input bit kill_done, input string tag);
        int n;
        logic [W-1:0] exp;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        op = o; a = x; b = y; in_valid = 1'b1;
        exp_q.push_back(ref_md(o, x, y));
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom);
        op = md_op_e'($urandom_range(0, 7));
        n = 1;
        check({tag, "_busy"}, {in_ready, busy}, 32'b01);
        while (!out_valid && n < W + 10) begin
            if (n == kill_at) begin
                kill = 1'b1;
                @(negedge clk);
                kill = 1'b0;
                check({tag, "_kill"}, {out_valid, busy, in_ready}, 32'b001);
                exp = exp_q.pop_front();
                return;
            end
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(ref_latency(o, x, y)));
        exp = exp_q.pop_front();
        check({tag, "_result"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, {result[29:0], out_valid, in_ready}, {exp[29:0], 2'b10});
        end
        if (kill_done) kill = 1'b1;
        else out_ready = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        out_ready = 1'b0;
        check({tag, "_release"}, {out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        md_op_e ro;
        logic [W-1:0] rx, ry;
        int kat;

        repeat (3) @(negedge clk);
        check("reset_state", {in_ready, out_valid, busy}, 32'b100);
        check("reset_result", result, '0);
        rst_n = 1'b1;

        run_op(MUL,    32'd7,         32'hFFFF_FFFD, 0, 0, 0, "mul_7_m3");
        run_op(MULH,   32'h8000_0000, 32'h8000_0000, 0, 0, 0, "mulh_min");
        run_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, "mulhu_max");
        run_op(MULHSU, 32'hFFFF_FFFF, 32'd2,         0, 0, 0, "mulhsu_m1");
        run_op(DIV,    32'hFFFF_FFF9, 32'd2,         0, 0, 0, "div_m7_2");
        run_op(REM,    32'hFFFF_FFF9, 32'd2,         0, 0, 0, "rem_m7_2");
        run_op(DIVU,   32'd100,       32'd7,         0, 0, 0, "divu_100_7");
        run_op(REMU,   32'd100,       32'd7,         0, 0, 0, "remu_100_7");
        run_op(DIVU,   32'd5,         32'd0,         0, 0, 0, "divu_by0");
        run_op(REMU,   32'd5,         32'd0,         0, 0, 0, "remu_by0");
        run_op(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, "div_ovf");
        run_op(REM,    32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, "rem_ovf");
        run_op(MUL,    32'd0,         32'd0,         0, 0, 0, "mul_zero");
        run_op(MULH,   32'h1234_5678, 32'h9ABC_DEF0, 5, 0, 0, "backpressure");
        run_op(DIV,    32'd1000,      32'd3,         0, 10, 0, "kill_calc");
        run_op(MULHU,  32'hDEAD_BEEF, 32'h0BAD_F00D, 2, 0, 1, "kill_done");

        // Flush while idle must block the accept.
        @(negedge clk);
        op = MUL; a = 32'd3; b = 32'd4; in_valid = 1'b1; kill = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; kill = 1'b0;
        check("kill_idle", {busy, in_ready, out_valid}, 32'b010);

        // Reset mid-CALC drops everything at once.
        @(negedge clk);
        op = DIVU; a = 32'd99; b = 32'd5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset", {in_ready, out_valid, busy}, 32'b100);
        check("async_reset_result", result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(REM, 32'hFFFF_FF9C, 32'd7, 0, 0, 0, "after_reset");

        for (int t = 0; t < 1200; t++) begin
            ro = md_op_e'($urandom_range(0, 7));
            rx = rand_opnd();
            ry = rand_opnd();
            kat = 0;
            if ($urandom_range(0, 9) == 0 && ref_latency(ro, rx, ry) > 1)
                kat = $urandom_range(1, W + 1);
            run_op(ro, rx, ry, $urandom_range(0, 3), kat, ($urandom_range(0, 9) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
